// File: rtl/nv_mac_pkg.sv
// nv_mac_pkg: shared precision codes, accumulator-stage states and width helpers for the MAC engine
package nv_mac_pkg;
  localparam logic PREC_INT16 = 1'b0;
  localparam logic PREC_INT8 = 1'b1;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic int tree_w(input int lanes, input int dw);
    return 2 * dw + $clog2(lanes);
  endfunction
  function automatic int out_w(input int lanes, input int dw, input int cnt_w);
    return tree_w(lanes, dw) + cnt_w;
  endfunction
endpackage

// File: rtl/nv_mac_lane.sv
// nv_mac_lane: one zero-skipping multiplier lane, INT16 or dual-INT8, 2*DW signed product
module nv_mac_lane import nv_mac_pkg::*; #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   dat_i,
  input  logic [DW-1:0]   wt_i,
  input  logic            en_i,
  input  logic            prec_i,
  output logic [2*DW-1:0] prod_o
);
  localparam int HW = DW / 2;
  logic [DW-1:0] d, w, p_lo, p_hi;
  logic [2*DW-1:0] p16;
  logic [DW:0] p8;
  // zero-flagged lanes present constant operands so the multipliers do not toggle
  assign d = en_i ? dat_i : '0;
  assign w = en_i ? wt_i : '0;
  assign p16 = {{DW{d[DW-1]}}, d} * {{DW{w[DW-1]}}, w};
  assign p_lo = {{HW{d[HW-1]}}, d[HW-1:0]} * {{HW{w[HW-1]}}, w[HW-1:0]};
  assign p_hi = {{HW{d[DW-1]}}, d[DW-1:HW]} * {{HW{w[DW-1]}}, w[DW-1:HW]};
  assign p8 = {p_lo[DW-1], p_lo} + {p_hi[DW-1], p_hi};
  assign prod_o = !en_i ? '0 : (prec_i == PREC_INT16) ? p16 : {{(DW-1){p8[DW]}}, p8};
endmodule

// File: rtl/nv_mac_accum_unit.sv
// nv_mac_accum_unit: 3-stage LANES-wide dot-product MAC accumulating cfg_acc_len beats per result
module nv_mac_accum_unit import nv_mac_pkg::*; #(
  parameter int LANES = 8,
  parameter int DW = 16,
  parameter int ACC_CNT_W = 8,
  localparam int TW = tree_w(LANES, DW),
  localparam int OUT_W = out_w(LANES, DW, ACC_CNT_W)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 cfg_reg_en,
  input  logic                 cfg_prec,
  input  logic [ACC_CNT_W-1:0] cfg_acc_len,
  input  logic [LANES*DW-1:0]  dat_actv_data,
  input  logic [LANES-1:0]     dat_actv_nz,
  input  logic                 dat_actv_pvld,
  input  logic [LANES*DW-1:0]  wt_actv_data,
  input  logic [LANES-1:0]     wt_actv_nz,
  output logic [OUT_W-1:0]     mac_out_data,
  output logic                 mac_out_pvld,
  output logic                 mac_busy
);
  logic [2*DW-1:0] prod_c [LANES];
  logic [2*DW-1:0] prod_q [LANES];
  logic [TW-1:0] sum_c, sum_q;
  logic [OUT_W-1:0] acc_q, acc_d, acc_nx, out_q, out_d, sum_x;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d, len_q, len_m1;
  logic prec_q, v1_q, v2_q, pvld_q, pvld_d, in_v, last;
  state_e state_q, state_d;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nv_mac_lane #(.DW(DW)) u_lane (
      .dat_i  (dat_actv_data[i*DW +: DW]),
      .wt_i   (wt_actv_data[i*DW +: DW]),
      .en_i   (dat_actv_nz[i] & wt_actv_nz[i]),
      .prec_i (prec_q),
      .prod_o (prod_c[i])
    );
  end
  assign in_v = dat_actv_pvld & ~cfg_reg_en;
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < LANES; j++) sum_c = sum_c + {{(TW-2*DW){prod_q[j][2*DW-1]}}, prod_q[j]};
    sum_x = {{(OUT_W-TW){sum_q[TW-1]}}, sum_q};
    len_m1 = (len_q == '0) ? '0 : len_q - ACC_CNT_W'(1);
    last = cnt_q == len_m1;
    acc_nx = (cnt_q == '0) ? sum_x : acc_q + sum_x;
    // a strobe already in S2 still fires alongside cfg_reg_en; everything behind it is flushed
    pvld_d = v2_q & last;
    out_d = pvld_d ? acc_nx : out_q;
    cnt_d = cfg_reg_en ? '0 : !v2_q ? cnt_q : last ? '0 : cnt_q + ACC_CNT_W'(1);
    acc_d = cfg_reg_en ? '0 : v2_q ? acc_nx : acc_q;
    state_d = cfg_reg_en ? IDLE : !v2_q ? state_q : last ? IDLE : ACCUM;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      prod_q <= '{default: '0};
      sum_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      prec_q <= PREC_INT16;
      len_q <= ACC_CNT_W'(1);
      cnt_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      pvld_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      if (in_v) prod_q <= prod_c;
      if (v1_q) sum_q <= sum_c;
      v1_q <= in_v;
      v2_q <= v1_q & ~cfg_reg_en;
      if (cfg_reg_en) begin
        prec_q <= cfg_prec;
        len_q <= cfg_acc_len;
      end
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      out_q <= out_d;
      pvld_q <= pvld_d;
      state_q <= state_d;
    end
  end
  assign mac_out_data = out_q;
  assign mac_out_pvld = pvld_q;
  assign mac_busy = (state_q == ACCUM) | v1_q | v2_q;
endmodule

// File: tb/tb_nv_mac_accum_unit.sv
// tb_nv_mac_accum_unit: directed + random stimulus against a beat/group level reference model
module tb_nv_mac_accum_unit;
  localparam int OW = 43;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cfg_en = 1'b0, cfg_prec = 1'b0, pvld = 1'b0;
  logic [7:0] cfg_len = '0, dnz = '0, wnz = '0;
  logic [127:0] dd = '0, wd = '0;
  logic [OW-1:0] out_data;
  logic out_pvld, busy;
  int total = 0, bad = 0, ecnt = 0;
  bit m_prec = 1'b0;
  int m_len = 1, m_cnt = 0;
  longint m_acc = 0, last_out = 0;
  typedef struct {int due; longint val;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nv_mac_accum_unit dut (
    .nvdla_core_clk (clk), .nvdla_core_rstn (rst_n),
    .cfg_reg_en (cfg_en), .cfg_prec (cfg_prec), .cfg_acc_len (cfg_len),
    .dat_actv_data (dd), .dat_actv_nz (dnz), .dat_actv_pvld (pvld),
    .wt_actv_data (wd), .wt_actv_nz (wnz),
    .mac_out_data (out_data), .mac_out_pvld (out_pvld), .mac_busy (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint dot(input logic [127:0] d, input logic [127:0] w,
                                 input logic [7:0] dn, input logic [7:0] wn, input bit prec);
    longint s = 0;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = d[i*16 +: 16];
      b = w[i*16 +: 16];
      if (dn[i] && wn[i]) begin
        if (!prec) s += longint'($signed(a)) * longint'($signed(b));
        else s += longint'($signed(a[7:0])) * longint'($signed(b[7:0]))
                + longint'($signed(a[15:8])) * longint'($signed(b[15:8]));
      end
    end
    return s;
  endfunction

  task automatic tick();
    bit ep, eb;
    @(posedge clk);
    #1;
    ecnt++;
    if (cfg_en) begin
      m_prec = cfg_prec;
      m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
      m_cnt = 0;
      m_acc = 0;
      while (q.size() > 0 && q[$].due > ecnt) void'(q.pop_back());
    end else if (pvld) begin
      m_acc += dot(dd, wd, dnz, wnz, m_prec);
      m_cnt++;
      if (m_cnt == m_len) begin
        q.push_back('{ecnt + 2, m_acc});
        m_cnt = 0;
        m_acc = 0;
      end
    end
    ep = q.size() > 0 && q[0].due == ecnt;
    if (ep) begin
      last_out = q[0].val;
      void'(q.pop_front());
    end
    eb = (m_cnt != 0) || (q.size() > 0);
    chk("pvld", 64'(out_pvld), 64'(ep));
    chk("data", 64'(out_data), 64'(last_out[OW-1:0]));
    chk("busy", 64'(busy), 64'(eb));
  endtask

  task automatic idle(input int n);
    pvld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cfg(input bit p, input logic [7:0] len, input bit v);
    cfg_en = 1'b1;
    cfg_prec = p;
    cfg_len = len;
    pvld = v;
    tick();
    cfg_en = 1'b0;
    pvld = 1'b0;
  endtask

  task automatic set_all(input logic [15:0] d, input logic [15:0] w, input logic [7:0] nz);
    dd = {8{d}};
    wd = {8{w}};
    dnz = nz;
    wnz = nz;
  endtask

  task automatic beat();
    pvld = 1'b1;
    tick();
    pvld = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_pvld", 64'(out_pvld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    cfg(0, 1, 0);
    set_all(16'h0002, 16'h0003, 8'hff);
    beat();
    idle(3);
    chk("t1_data", 64'(out_data), 64'd48);

    cfg(0, 4, 0);
    dd = {$urandom, $urandom, $urandom, $urandom};
    wd = {$urandom, $urandom, $urandom, $urandom};
    dd[15:0] = 16'h7fff;
    wd[15:0] = 16'h7fff;
    dnz = 8'hff;
    wnz = 8'h01;
    repeat (4) beat();
    idle(3);
    chk("t2_data", 64'(out_data), 64'hFFFC0004);

    cfg(1, 1, 0);
    set_all(16'hff01, 16'h0202, 8'hff);
    beat();
    idle(3);
    chk("t3_zero", 64'(out_data), 64'd0);
    set_all(16'h0101, 16'h0303, 8'hff);
    beat();
    idle(3);
    chk("t3_int8", 64'(out_data), 64'd48);

    cfg(0, 2, 0);
    set_all(16'd1, 16'd1, 8'hff);
    beat();
    idle(2);
    set_all(16'd2, 16'd1, 8'hff);
    beat();
    set_all(16'd3, 16'd1, 8'hff);
    beat();
    set_all(16'd1, 16'd1, 8'hff);
    beat();
    chk("t4_first", 64'(out_data), 64'd24);
    idle(3);
    chk("t4_second", 64'(out_data), 64'd32);

    cfg(0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      set_all(16'(k), 16'd1, 8'hff);
      beat();
    end
    idle(3);
    chk("t4_len0", 64'(out_data), 64'd24);

    cfg(0, 1, 0);
    set_all(16'd5, 16'd1, 8'hff);
    beat();
    idle(1);
    cfg(1, 3, 1);
    chk("cfg_strobe", 64'(out_data), 64'd40);
    set_all(16'h0101, 16'h0101, 8'hff);
    repeat (3) beat();
    idle(3);
    chk("cfg_group", 64'(out_data), 64'd48);

    cfg(0, 4, 0);
    set_all(16'd5, 16'd5, 8'hff);
    repeat (2) beat();
    cfg(0, 4, 0);
    chk("t5_busy", 64'(busy), 64'd0);
    set_all(16'd1, 16'd1, 8'hff);
    repeat (4) beat();
    idle(3);
    chk("t5_data", 64'(out_data), 64'd32);

    cfg(0, 3, 0);
    set_all(16'd1, 16'd1, 8'hff);
    repeat (2) beat();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_pvld", 64'(out_pvld), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_prec = 1'b0;
    m_len = 1;
    m_cnt = 0;
    m_acc = 0;
    last_out = 0;
    q.delete();
    dd = 128'h1;
    wd = 128'h1;
    dnz = 8'h01;
    wnz = 8'h01;
    beat();
    idle(3);
    chk("t6_after", 64'(out_data), 64'd1);

    for (int k = 0; k < 400; k++) begin
      cfg_prec = 1'($urandom_range(0, 1));
      cfg_len = 8'($urandom_range(0, 5));
      dd = {$urandom, $urandom, $urandom, $urandom};
      wd = {$urandom, $urandom, $urandom, $urandom};
      dnz = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
      wnz = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
      pvld = $urandom_range(0, 9) < 7;
      cfg_en = $urandom_range(0, 19) == 0;
      tick();
    end
    cfg_en = 1'b0;
    idle(4);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
